feature_frame_capture: RTL and testbench
========================================

Name: feature_frame_capture

Overview:
- Upstream stage of the arrhythmia decision-tree classifier.
- Accepts one byte-serial frame of quantised features per patient record. Extracts the five features the tree consumes (indices 13, 27, 235, 264, 278) and presents them as a registered, valid/ready-handshaked bundle to the combinational tree.
- Decouples the serial sensor/host interface from the classifier, so a new frame can be captured while the previous bundle is still held.

Parameters:
- NUM_FEATURES, 279, feature bytes per frame; index 0 is the first beat.
- FW, 8, feature width in bits.
- IDX0..IDX4, 13/27/235/264/278, frame indices routed to f0..f4. Strictly increasing, all < NUM_FEATURES.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_sof  in  1  beat is feature index 0 of a new frame.
- in_data  in  FW  feature byte.
- in_ready  out  1  block can accept a beat.
- feat_valid  out  1  f0..f4 hold a complete frame's features.
- feat_ready  in  1  classifier/consumer takes the bundle.
- f0..f4  out  FW each  features IDX0..IDX4 (drive X13, X27, X235, X264, X278).
- frame_err  out  1  one-cycle pulse on framing error.
- frames_done  out  CNT_W  count of bundles delivered; saturates at all-ones.

Behaviour:
- Reset (async assert, sync-released deassert): state=IDLE, beat index=0, working and output registers=0, feat_valid=0, frame_err=0, frames_done=0. in_ready=1 from the first cycle after reset.
- A beat is accepted when in_valid && in_ready on a rising edge.
- FSM states: IDLE, CAPT, WAIT.
- IDLE, in_ready=1:
  - Accepted beat with in_sof=1: treat as index 0, store into the working register if IDX0==0, set idx=1, go to CAPT.
  - Accepted beat with in_sof=0: dropped, frame_err pulses, stay in IDLE.
- CAPT, in_ready=1:
  - Accepted beat with in_sof=0: if idx matches IDXk, store into working slot k; then idx++.
  - Accepted beat with in_sof=1: frame_err pulses. The beat restarts capture as index 0 (idx=1). Working slots from the aborted frame are not cleared; they are overwritten by the new frame.
  - Final beat (idx==NUM_FEATURES-1): the frame is complete; idx returns to 0.
    - If the output is free (feat_valid==0, or feat_valid && feat_ready in that cycle): load f0..f4 from working (the final beat's data is bypassed into its slot), set feat_valid=1 next cycle, go to IDLE.
    - Otherwise go to WAIT.
- WAIT: in_ready=0; the beat index is frozen; no beats are accepted. When feat_ready=1, the bundle is released and working is transferred into the output in the same edge. feat_valid stays 1 (new bundle). Go to IDLE.
- Output handshake:
  - feat_valid clears on feat_valid && feat_ready, unless it is reloaded in the same edge.
  - f0..f4 are stable while feat_valid && !feat_ready.
  - frames_done increments once per delivered bundle, i.e. once per feat_valid && feat_ready cycle.
- Latency: feat_valid rises exactly 1 cycle after the final beat is accepted when the output is free. Sustained throughput is 1 beat/cycle when feat_ready is held high.
- Simultaneous events:
  - Final beat plus consumer draining in the same cycle: direct load, no WAIT.
  - frame_err with a delivery in the same cycle: both take effect independently.
- in_ready is combinational from state only (no dependency on in_valid).
- Reset mid-frame discards all partial and held data.

Decomposition:
- Package ptree_feat_pkg holds:
  - FW, NUM_FEATURES, and the IDX constants for the arrhythmia model.
  - A typedef for the 5-entry feature bundle.
  - The FSM state enum.
- One sub-module, feat_out_slot: the output register, the feat_valid/feat_ready handshake and the frames_done saturating counter. The top module holds the FSM, beat index and working registers.

Test Plan:
- Nominal frame: send 279 beats with data=index[7:0] and in_sof on the first, feat_ready=1 → feat_valid one cycle after the last beat; f0..f4 = 13, 27, 235, 8, 22; frames_done=1.
- Backpressure: feat_ready=0, send two full frames back-to-back → first bundle held stable; after the second frame's last beat, in_ready=0 (WAIT). Raise feat_ready one cycle → frames_done=1, f reloads with the second frame's values, in_ready=1 next cycle.
- Mid-frame SOF: after 100 beats assert in_sof with data 0xAA, then continue 278 beats → one frame_err pulse; the bundle reflects the new frame only; frames_done=1.
- Stray beats: in IDLE send 3 beats with in_sof=0 → 3 frame_err pulses, no feat_valid, idx stays 0.
- Async reset at beat 200 (mid-cycle pulse of rst_n) → all outputs 0 immediately; the next full frame captures correctly.
- Saturation: force frames_done to 0xFFFE, deliver 3 bundles → holds at 0xFFFF.

Source files
------------

// File: rtl/feature_frame_capture_pkg.sv
// ptree_feat_pkg: widths, feature indices, bundle type and FSM states for the frame capture block
package ptree_feat_pkg;
    localparam int FW           = 8;
    localparam int NUM_FEATURES = 279;
    localparam int CNT_W        = 16;
    localparam int NF           = 5;
    localparam int IDX_W        = $clog2(NUM_FEATURES);
    localparam int IDX0         = 13;
    localparam int IDX1         = 27;
    localparam int IDX2         = 235;
    localparam int IDX3         = 264;
    localparam int IDX4         = 278;
    localparam int IDX [NF]     = '{IDX0, IDX1, IDX2, IDX3, IDX4};

    typedef logic [FW-1:0] feat_t;
    typedef feat_t [NF-1:0] feat_bundle_t;
    typedef enum logic [1:0] {IDLE, CAPT, WAIT} state_t;
endpackage

// File: rtl/feature_frame_capture_if.sv
// feature_frame_capture_if: serial beat input, feature bundle output and status of the capture block
interface feature_frame_capture_if #(parameter int CNT_W = ptree_feat_pkg::CNT_W);
    import ptree_feat_pkg::*;
    logic             in_valid;
    logic             in_sof;
    logic [FW-1:0]    in_data;
    logic             in_ready;
    logic             feat_valid;
    logic             feat_ready;
    logic [FW-1:0]    f0, f1, f2, f3, f4;
    logic             frame_err;
    logic [CNT_W-1:0] frames_done;

    modport master (
        output in_valid, in_sof, in_data, feat_ready,
        input  in_ready, feat_valid, f0, f1, f2, f3, f4, frame_err, frames_done
    );
    modport slave (
        input  in_valid, in_sof, in_data, feat_ready,
        output in_ready, feat_valid, f0, f1, f2, f3, f4, frame_err, frames_done
    );
endinterface

// File: rtl/feature_frame_capture_out_slot.sv
// feat_out_slot: held feature bundle with valid/ready handshake and saturating delivery counter
module feat_out_slot import ptree_feat_pkg::*; #(
    parameter int CNT_W = ptree_feat_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  feat_bundle_t     i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic             o_free,
    output feat_bundle_t     o_data,
    output logic [CNT_W-1:0] o_count
);
    logic             r_valid;
    feat_bundle_t     r_data;
    logic [CNT_W-1:0] r_count;
    logic             w_deliver;

    assign w_deliver = r_valid && i_ready;
    assign o_free    = !r_valid || i_ready;
    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_count   = r_count;

    // A load wins over a same-cycle delivery so the new bundle stays valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_valid <= i_load || (r_valid && !i_ready);
            if (i_load) r_data <= i_data;
            if (w_deliver && r_count != '1) r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/feature_frame_capture.sv
// feature_frame_capture: captures the five tree features from a byte-serial frame into a handshaked bundle
module feature_frame_capture import ptree_feat_pkg::*; #(
    parameter int CNT_W = ptree_feat_pkg::CNT_W
) (
    input logic                    clk,
    input logic                    rst_n,
    feature_frame_capture_if.slave bus
);
    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt, w_bidx;
    feat_bundle_t     r_work, w_work_nxt, w_out;
    logic             r_err, w_acc, w_take, w_last, w_err, w_load, w_free;

    assign bus.in_ready = r_state != WAIT;
    assign w_acc        = bus.in_valid && bus.in_ready;

    // Beat classification, working-slot update, index and next state
    always_comb begin
        w_bidx      = (bus.in_sof || r_state == IDLE) ? '0 : r_idx;
        w_take      = w_acc && (bus.in_sof || r_state == CAPT);
        w_err       = w_acc && ((r_state == IDLE && !bus.in_sof) || (r_state == CAPT && bus.in_sof));
        w_last      = w_take && w_bidx == IDX_W'(NUM_FEATURES - 1);
        w_load      = (w_last || r_state == WAIT) && w_free;
        w_idx_nxt   = w_take ? (w_last ? '0 : w_bidx + 1'b1) : r_idx;
        w_state_nxt = (w_last || r_state == WAIT) ? (w_free ? IDLE : WAIT) : (w_take ? CAPT : r_state);
        w_work_nxt  = r_work;
        for (int k = 0; k < NF; k++)
            if (w_take && w_bidx == IDX_W'(IDX[k])) w_work_nxt[k] = bus.in_data;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Beat index, working slots and framing-error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_work <= '0;
            r_err  <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_work <= w_work_nxt;
            r_err  <= w_err;
        end
    end

    feat_out_slot #(.CNT_W(CNT_W)) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (w_work_nxt),
        .i_ready (bus.feat_ready),
        .o_valid (bus.feat_valid),
        .o_free  (w_free),
        .o_data  (w_out),
        .o_count (bus.frames_done)
    );

    assign bus.f0        = w_out[0];
    assign bus.f1        = w_out[1];
    assign bus.f2        = w_out[2];
    assign bus.f3        = w_out[3];
    assign bus.f4        = w_out[4];
    assign bus.frame_err = r_err;
endmodule

// File: tb/tb_feature_frame_capture.sv
// tb_feature_frame_capture: randomized frames checked against a frame-level reference model
module tb_feature_frame_capture;
    localparam int NFEAT = 279;
    localparam int FI [5] = '{13, 27, 235, 264, 278};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    feature_frame_capture_if bus ();
    feature_frame_capture_if #(.CNT_W(2)) bus2 ();

    feature_frame_capture dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    feature_frame_capture #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus2.in_valid   = bus.in_valid;
    assign bus2.in_sof     = bus.in_sof;
    assign bus2.in_data    = bus.in_data;
    assign bus2.feat_ready = bus.feat_ready;

    int n_chk = 0, n_fail = 0;
    int n_del = 0, n_err_obs = 0, n_err_exp = 0;
    int pos = 0;
    logic [7:0] cur [NFEAT];
    logic [39:0] q [$];
    bit rand_rdy = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // frame-level reference: a bundle exists once NFEAT consecutive beats follow an SOF
    task automatic model(input logic s, input logic [7:0] d);
        logic [39:0] b;
        if (s) begin
            if (pos != 0) n_err_exp++;
            pos = 0;
        end else if (pos == 0) begin
            n_err_exp++;
            return;
        end
        cur[pos] = d;
        pos++;
        if (pos == NFEAT) begin
            for (int k = 0; k < 5; k++) b[8*k +: 8] = cur[FI[k]];
            q.push_back(b);
            pos = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic s, input logic [7:0] d);
        int g = 0;
        bus.in_valid = 1'b1;
        bus.in_sof = s;
        bus.in_data = d;
        while (!bus.in_ready && g < 2000) begin
            tick();
            g++;
        end
        if (g == 2000) check("ready_timeout", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        model(s, d);
    endtask

    task automatic send_frame(input bit idx_data, input int gap_pct, input int abort_pm, input int nbeats);
        logic s;
        for (int i = 0; i < nbeats; i++) begin
            s = (i == 0) || (abort_pm > 0 && $urandom_range(0, 999) < abort_pm);
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) tick();
            beat(s, idx_data ? 8'(i) : 8'($urandom));
        end
    endtask

    task automatic check_f_front(input string tag);
        check({tag, "_f0"}, 32'(bus.f0), 32'(q[0][7:0]));
        check({tag, "_f1"}, 32'(bus.f1), 32'(q[0][15:8]));
        check({tag, "_f2"}, 32'(bus.f2), 32'(q[0][23:16]));
        check({tag, "_f3"}, 32'(bus.f3), 32'(q[0][31:24]));
        check({tag, "_f4"}, 32'(bus.f4), 32'(q[0][39:32]));
    endtask

    // scoreboard: every delivered bundle must be the oldest completed frame
    always @(negedge clk) begin
        if (bus.frame_err) n_err_obs++;
        if (bus.feat_valid) begin
            if (q.size() == 0) check("spurious_valid", 32'(bus.feat_valid), 0);
            else if (bus.feat_ready) begin
                check_f_front("deliver");
                check("count_before", 32'(bus.frames_done), 32'(n_del));
                check("sat_before", 32'(bus2.frames_done), 32'((n_del > 3) ? 3 : n_del));
                void'(q.pop_front());
                n_del++;
            end
        end
    end

    initial forever begin
        tick();
        if (rand_rdy) bus.feat_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.in_data = '0;
        bus.feat_ready = 1'b0;
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_valid", 32'(bus.feat_valid), 0);
        check("rst_done", 32'(bus.frames_done), 0);
        check("rst_err", 32'(bus.frame_err), 0);
        check("rst_f0", 32'(bus.f0), 0);
        check("rst_f4", 32'(bus.f4), 0);
        #10 rst_n = 1'b1;
        tick();

        // nominal frame, data = index
        bus.feat_ready = 1'b1;
        send_frame(1, 0, 0, NFEAT);
        check("lat_valid", 32'(bus.feat_valid), 1);
        check("nom_f0", 32'(bus.f0), 13);
        check("nom_f1", 32'(bus.f1), 27);
        check("nom_f2", 32'(bus.f2), 235);
        check("nom_f3", 32'(bus.f3), 8);
        check("nom_f4", 32'(bus.f4), 22);
        tick();
        check("nom_done", 32'(bus.frames_done), 1);
        check("nom_valid_clr", 32'(bus.feat_valid), 0);

        // backpressure: two frames while the consumer stalls
        bus.feat_ready = 1'b0;
        send_frame(0, 0, 0, NFEAT);
        send_frame(0, 0, 0, NFEAT);
        check("bp_wait_ready", 32'(bus.in_ready), 0);
        check("bp_held_valid", 32'(bus.feat_valid), 1);
        check_f_front("bp_held");
        bus.in_valid = 1'b1;
        bus.in_data = 8'h5A;
        tick();
        bus.in_valid = 1'b0;
        check("bp_frozen", 32'(bus.in_ready), 0);
        check_f_front("bp_stable");
        bus.feat_ready = 1'b1;
        tick();
        bus.feat_ready = 1'b0;
        check("bp_release_ready", 32'(bus.in_ready), 1);
        check("bp_reload_valid", 32'(bus.feat_valid), 1);
        check("bp_done", 32'(bus.frames_done), 2);
        check_f_front("bp_reload");
        bus.feat_ready = 1'b1;
        tick();

        // mid-frame SOF restarts the frame
        e0 = n_err_obs;
        send_frame(0, 0, 0, 100);
        beat(1'b1, 8'hAA);
        for (int i = 0; i < NFEAT - 1; i++) beat(1'b0, 8'($urandom));
        tick();
        tick();
        check("sof_err_pulses", 32'(n_err_obs - e0), 1);
        check("sof_done", 32'(bus.frames_done), 4);

        // stray beats in IDLE
        e0 = n_err_obs;
        for (int i = 0; i < 3; i++) beat(1'b0, 8'($urandom));
        tick();
        tick();
        check("stray_err_pulses", 32'(n_err_obs - e0), 3);
        check("stray_valid", 32'(bus.feat_valid), 0);

        // async reset in the middle of a frame
        send_frame(0, 0, 0, 200);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.feat_valid), 0);
        check("arst_done", 32'(bus.frames_done), 0);
        check("arst_f2", 32'(bus.f2), 0);
        check("arst_in_ready", 32'(bus.in_ready), 1);
        pos = 0;
        q.delete();
        n_del = 0;
        #3 rst_n = 1'b1;
        tick();
        send_frame(0, 0, 0, NFEAT);
        tick();
        check("arst_next_done", 32'(bus.frames_done), 1);

        // saturation of the narrow counter instance
        for (int i = 0; i < 4; i++) send_frame(0, 0, 0, NFEAT);
        tick();
        check("sat_wide", 32'(bus.frames_done), 5);
        check("sat_narrow", 32'(bus2.frames_done), 3);

        // random traffic: gaps, stalls, aborts and stray beats
        rand_rdy = 1;
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 3) == 0) beat(1'b0, 8'($urandom));
            send_frame(0, 20, 3, NFEAT);
        end
        rand_rdy = 0;
        bus.feat_ready = 1'b1;
        repeat (6) tick();
        check("end_queue_empty", 32'(q.size()), 0);
        check("end_err_count", 32'(n_err_obs), 32'(n_err_exp));
        check("end_done", 32'(bus.frames_done), 32'(n_del));
        check("end_sat", 32'(bus2.frames_done), 32'((n_del > 3) ? 3 : n_del));
        check("end_valid", 32'(bus.feat_valid), 0);
        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end
endmodule
